// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot and auto-reload modes.
//   clk    in   clock, all state updates on posedge
//   reset  in   synchronous active-high reset
//   addr   in   [1:0] word offset: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=unused
//   we     in   write strobe
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] combinational read data for addr, zero-extended
//   irq    out  irq_flag gated by CTRL.IM
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic             flag_q, flag_d;
  logic             en, mode1, wr_ctrl, wr_preset, term;
  assign en        = ctrl_q[0];
  assign mode1     = ctrl_q[2:1] == 2'b01;
  assign wr_ctrl   = we && addr == 2'd0;
  assign wr_preset = we && addr == 2'd1;
  // terminal count: a count of 0 or 1 ends the period without wrapping
  assign term      = state_q == CNT && en && count_q <= CNT_W'(1);
  always_comb begin
    state_d  = state_q == IDLE ? (en ? LOAD : IDLE) :
               state_q == LOAD ? CNT :
               state_q == CNT  ? (!en ? IDLE : term ? INT : CNT) : IDLE;
    count_d  = state_q == LOAD ? preset_q :
               (state_q == CNT && en) ? (term ? '0 : count_q - CNT_W'(1)) : count_q;
    // a CPU write to CTRL overrides the one-shot EN clear in INT
    ctrl_d   = wr_ctrl ? wdata[3:0] :
               (state_q == INT && !mode1) ? {ctrl_q[3:1], 1'b0} : ctrl_q;
    preset_d = wr_preset ? wdata[CNT_W-1:0] : preset_q;
    // a register write clears the flag even on the cycle it would be set
    flag_d   = (wr_ctrl || wr_preset) ? 1'b0 :
               term ? 1'b1 :
               (state_q == INT && mode1) ? 1'b0 : flag_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end
  assign rdata = addr == 2'd0 ? {28'b0, ctrl_q} :
                 addr == 2'd1 ? 32'(preset_q) :
                 addr == 2'd2 ? 32'(count_q) : '0;
  assign irq   = flag_q & ctrl_q[3];
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scoreboard bench for timer_counter.
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       tag;
    bit          is_irq;
    logic [1:0]  a;
    logic [31:0] exp;
  } item_t;
  item_t sb[$];
  timer_counter #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask
  task automatic exp_rd(input string t, input logic [1:0] a, input logic [31:0] e);
    sb.push_back('{t, 1'b0, a, e});
  endtask
  task automatic exp_irq(input string t, input logic e);
    sb.push_back('{t, 1'b1, 2'd0, {31'b0, e}});
  endtask
  task automatic drain();
    item_t it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (!it.is_irq) addr = it.a;
      #1;
      obs = it.is_irq ? {31'b0, irq} : rdata;
      checks++;
      assert (obs === it.exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tick(2);
    reset = 1'b0;
    exp_rd("rst_ctrl", 2'd0, 32'h0);
    exp_rd("rst_preset", 2'd1, 32'h0);
    exp_rd("rst_count", 2'd2, 32'h0);
    exp_irq("rst_irq", 1'b0);
    drain();
    // one-shot, PRESET=5: COUNT 5..0, irq after edge 7
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    exp_rd("t1_count_e2", 2'd2, 32'd5);
    exp_irq("t1_irq_e2", 1'b0);
    drain();
    for (int k = 3; k <= 7; k++) begin
      tick(1);
      exp_rd($sformatf("t1_count_e%0d", k), 2'd2, 32'(7 - k));
      exp_irq($sformatf("t1_irq_e%0d", k), k == 7);
      drain();
    end
    tick(2);
    exp_irq("t1_irq_held", 1'b1);
    exp_rd("t1_ctrl_en_clr", 2'd0, 32'h8);
    exp_rd("t1_count_zero", 2'd2, 32'h0);
    drain();
    wr(2'd0, 32'h0);
    exp_irq("t1_irq_dropped", 1'b0);
    drain();
    // auto-reload, PRESET=3: pulse at edges 5, 11, 17
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 18; e++) begin
      tick(1);
      exp_irq($sformatf("t2_irq_e%0d", e), e == 5 || e == 11 || e == 17);
      if (e == 2 || e == 8 || e == 14) exp_rd($sformatf("t2_reload_e%0d", e), 2'd2, 32'd3);
      drain();
    end
    exp_rd("t2_ctrl_en_kept", 2'd0, 32'hB);
    drain();
    wr(2'd0, 32'h0);
    tick(3);
    // one-shot with IM=0: flag set but masked, then CTRL write clears it
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      exp_irq($sformatf("t3_irq_e%0d", e), 1'b0);
      drain();
    end
    exp_rd("t3_ctrl", 2'd0, 32'h0);
    drain();
    wr(2'd0, 32'h8);
    exp_irq("t3_irq_after_im", 1'b0);
    drain();
    tick(1);
    exp_irq("t3_irq_later", 1'b0);
    drain();
    // disable mid-count freezes COUNT, re-enable reloads
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    tick(62);
    exp_rd("t4_count_40", 2'd2, 32'd40);
    drain();
    wr(2'd0, 32'h8);
    tick(3);
    exp_rd("t4_frozen", 2'd2, 32'd39);
    exp_irq("t4_irq", 1'b0);
    drain();
    wr(2'd0, 32'h9);
    tick(2);
    exp_rd("t4_reload", 2'd2, 32'd100);
    drain();
    wr(2'd0, 32'h0);
    tick(3);
    // reset mid-count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(5);
    exp_rd("t5_count_2", 2'd2, 32'd2);
    drain();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_rd("t5_ctrl", 2'd0, 32'h0);
    exp_rd("t5_preset", 2'd1, 32'h0);
    exp_rd("t5_count", 2'd2, 32'h0);
    exp_irq("t5_irq", 1'b0);
    drain();
    tick(8);
    exp_irq("t5_irq_later", 1'b0);
    exp_rd("t5_count_later", 2'd2, 32'h0);
    drain();
    // PRESET=0: irq at edge 3; writes to COUNT are ignored
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(2);
    exp_irq("t6_irq_e2", 1'b0);
    drain();
    tick(1);
    exp_irq("t6_irq_e3", 1'b1);
    drain();
    wr(2'd2, 32'h55);
    exp_rd("t6_count_ro", 2'd2, 32'h0);
    exp_rd("t6_addr3", 2'd3, 32'h0);
    exp_irq("t6_irq_kept", 1'b1);
    drain();
    wr(2'd0, 32'h0);
    tick(3);
    // CTRL write in the INT cycle wins over the EN clear and clears the flag
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(3);
    exp_irq("t7_irq_e3", 1'b1);
    drain();
    wr(2'd0, 32'h9);
    exp_rd("t7_ctrl_cpu_wins", 2'd0, 32'h9);
    exp_irq("t7_irq_cleared", 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
